seq_decode_execute_pc: RTL and testbench

Combined decode/write-back, execute and PC-select stage of the single-cycle Y86-64 SEQ processor. It sits between fetch (which supplies icode/ifun/rA/rB/valC/valP) and data memory (which returns valM). It holds the 15-entry register file and the condition codes, computes valA/valB/valE/Cnd, and selects the next PC. State commits on the rising clock edge that ends the instruction.

---
 rtl/seq_decode_execute_pc.sv | 215 +++++++++++++++++++++
 tb/tb_seq_decode_execute_pc.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/seq_decode_execute_pc.sv
// Y86-64 SEQ decode/write-back, execute and PC-select stage.
// Holds the 15-entry register file and condition codes; all other logic is combinational.
module seq_decode_execute_pc (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic [63:0] valC,
  input  logic [63:0] valP,
  input  logic [63:0] valM,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic [63:0] valE,
  output logic        Cnd,
  output logic        ZF,
  output logic        SF,
  output logic        OF,
  output logic [63:0] PC_next,
  output logic [63:0] rax,
  output logic [63:0] rcx,
  output logic [63:0] rdx,
  output logic [63:0] rbx,
  output logic [63:0] rsp,
  output logic [63:0] rbp,
  output logic [63:0] rsi,
  output logic [63:0] rdi,
  output logic [63:0] r8,
  output logic [63:0] r9,
  output logic [63:0] r10,
  output logic [63:0] r11,
  output logic [63:0] r12,
  output logic [63:0] r13,
  output logic [63:0] r14
);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_CMOV   = 4'h2;
  localparam logic [3:0] I_IRMOV  = 4'h3;
  localparam logic [3:0] I_RMMOV  = 4'h4;
  localparam logic [3:0] I_MRMOV  = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSH   = 4'hA;
  localparam logic [3:0] I_POP    = 4'hB;
  localparam logic [3:0] R_RSP    = 4'h4;
  localparam logic [3:0] R_NONE   = 4'hF;

  logic [63:0] rf_q [15];
  logic [63:0] rf_d [15];
  logic        zf_q, sf_q, of_q;
  logic        zf_d, sf_d, of_d;

  logic [3:0]  src_a, src_b, dst_e, dst_m;
  logic [63:0] alu_a, alu_b;
  logic        zf_new, sf_new, of_new, cc_en;

  // Source and destination register selection.
  always_comb begin
    src_a = R_NONE;
    src_b = R_NONE;
    dst_m = R_NONE;
    case (icode)
      I_CMOV, I_RMMOV, I_OPQ, I_PUSH: src_a = rA;
      I_RET, I_POP:                   src_a = R_RSP;
      default:                        src_a = R_NONE;
    endcase
    case (icode)
      I_RMMOV, I_MRMOV, I_OPQ:        src_b = rB;
      I_CALL, I_RET, I_PUSH, I_POP:   src_b = R_RSP;
      default:                        src_b = R_NONE;
    endcase
    if (icode == I_MRMOV || icode == I_POP) dst_m = rA;
  end

  // Register read ports; ID F never matches an entry so it reads as zero.
  always_comb begin
    valA = '0;
    valB = '0;
    for (int i = 0; i < 15; i++) begin
      if (src_a == 4'(i)) valA = rf_q[i];
      if (src_b == 4'(i)) valB = rf_q[i];
    end
  end

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (icode)
      I_CMOV, I_OPQ:              alu_a = valA;
      I_IRMOV, I_RMMOV, I_MRMOV:  alu_a = valC;
      I_CALL, I_PUSH:             alu_a = -64'sd8;
      I_RET, I_POP:               alu_a = 64'd8;
      default:                    alu_a = '0;
    endcase
    case (icode)
      I_RMMOV, I_MRMOV, I_OPQ, I_CALL, I_RET, I_PUSH, I_POP: alu_b = valB;
      default:                                               alu_b = '0;
    endcase
  end

  // ALU and the condition codes an OPq would produce.
  always_comb begin
    valE   = alu_b + alu_a;
    of_new = 1'b0;
    cc_en  = 1'b0;
    if (icode == I_OPQ) begin
      cc_en = 1'b1;
      case (ifun)
        4'h0: begin
          valE   = alu_b + alu_a;
          of_new = (alu_a[63] == alu_b[63]) && (valE[63] != alu_a[63]);
        end
        4'h1: begin
          valE   = alu_b - alu_a;
          of_new = (alu_a[63] != alu_b[63]) && (valE[63] != alu_b[63]);
        end
        4'h2: valE = alu_b & alu_a;
        4'h3: valE = alu_b ^ alu_a;
        default: begin
          valE  = '0;
          cc_en = 1'b0;
        end
      endcase
    end
    zf_new = (valE == 64'd0);
    sf_new = valE[63];
  end

  // Condition evaluated against the codes left by the previous instruction.
  always_comb begin
    case (ifun)
      4'h0:    Cnd = 1'b1;
      4'h1:    Cnd = (sf_q ^ of_q) | zf_q;
      4'h2:    Cnd = sf_q ^ of_q;
      4'h3:    Cnd = zf_q;
      4'h4:    Cnd = ~zf_q;
      4'h5:    Cnd = ~(sf_q ^ of_q);
      4'h6:    Cnd = ~(sf_q ^ of_q) & ~zf_q;
      default: Cnd = 1'b0;
    endcase
  end

  always_comb begin
    case (icode)
      I_IRMOV, I_OPQ:               dst_e = rB;
      I_CMOV:                       dst_e = Cnd ? rB : R_NONE;
      I_CALL, I_RET, I_PUSH, I_POP: dst_e = R_RSP;
      default:                      dst_e = R_NONE;
    endcase
  end

  always_comb begin
    case (icode)
      I_JXX:   PC_next = Cnd ? valC : valP;
      I_CALL:  PC_next = valC;
      I_RET:   PC_next = valM;
      default: PC_next = valP;
    endcase
  end

  // Next state; the memory write is applied last so valM wins on dstE == dstM.
  always_comb begin
    for (int i = 0; i < 15; i++) begin
      rf_d[i] = rf_q[i];
      if (dst_e == 4'(i)) rf_d[i] = valE;
      if (dst_m == 4'(i)) rf_d[i] = valM;
    end
    zf_d = zf_q;
    sf_d = sf_q;
    of_d = of_q;
    if (cc_en) begin
      zf_d = zf_new;
      sf_d = sf_new;
      of_d = of_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) rf_q[i] <= '0;
      zf_q <= 1'b1;
      sf_q <= 1'b0;
      of_q <= 1'b0;
    end else begin
      for (int i = 0; i < 15; i++) rf_q[i] <= rf_d[i];
      zf_q <= zf_d;
      sf_q <= sf_d;
      of_q <= of_d;
    end
  end

  assign ZF  = zf_q;
  assign SF  = sf_q;
  assign OF  = of_q;
  assign rax = rf_q[0];
  assign rcx = rf_q[1];
  assign rdx = rf_q[2];
  assign rbx = rf_q[3];
  assign rsp = rf_q[4];
  assign rbp = rf_q[5];
  assign rsi = rf_q[6];
  assign rdi = rf_q[7];
  assign r8  = rf_q[8];
  assign r9  = rf_q[9];
  assign r10 = rf_q[10];
  assign r11 = rf_q[11];
  assign r12 = rf_q[12];
  assign r13 = rf_q[13];
  assign r14 = rf_q[14];

endmodule

// File: tb/tb_seq_decode_execute_pc.sv
// Directed bench for seq_decode_execute_pc: hand-computed register, CC and PC expectations.
module tb_seq_decode_execute_pc;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP, valM;
  logic [63:0] valA, valB, valE, PC_next;
  logic        Cnd, ZF, SF, OF;
  logic [63:0] rax, rcx, rdx, rbx, rsp, rbp, rsi, rdi;
  logic [63:0] r8, r9, r10, r11, r12, r13, r14;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_decode_execute_pc dut (
    .clk(clk), .rst(rst), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .valC(valC), .valP(valP), .valM(valM),
    .valA(valA), .valB(valB), .valE(valE), .Cnd(Cnd),
    .ZF(ZF), .SF(SF), .OF(OF), .PC_next(PC_next),
    .rax(rax), .rcx(rcx), .rdx(rdx), .rbx(rbx), .rsp(rsp), .rbp(rbp),
    .rsi(rsi), .rdi(rdi), .r8(r8), .r9(r9), .r10(r10), .r11(r11),
    .r12(r12), .r13(r13), .r14(r14)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic instr(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] a,
                       input logic [3:0] b, input logic [63:0] c, input logic [63:0] p,
                       input logic [63:0] m);
    icode = ic; ifun = fn; rA = a; rB = b; valC = c; valP = p; valM = m;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cc(input string tag, input logic z, input logic s, input logic o);
    chk({tag, ".cc"}, {61'd0, ZF, SF, OF}, {61'd0, z, s, o});
  endtask

  initial begin
    rst = 1'b1;
    instr(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 64'd0);
    tick();
    rst = 1'b0;
    chk("rst.rax", rax, 64'd0);
    chk("rst.rsp", rsp, 64'd0);
    chk("rst.r14", r14, 64'd0);
    chk_cc("rst", 1'b1, 1'b0, 1'b0);

    // irmovq $120, %rdx
    instr(4'h3, 4'h0, 4'hF, 4'h2, 64'd120, 64'd10, 64'd0);
    chk("irmov.valE", valE, 64'd120);
    tick();
    chk("irmov.rdx", rdx, 64'd120);

    instr(4'h3, 4'h0, 4'hF, 4'h1, 64'd100, 64'd20, 64'd0); tick();
    instr(4'h3, 4'h0, 4'hF, 4'h5, 64'd4, 64'd30, 64'd0);   tick();
    // addq %rcx, %rbp
    instr(4'h6, 4'h0, 4'h1, 4'h5, 64'd0, 64'd32, 64'd0);
    chk("add.valA", valA, 64'd100);
    chk("add.valB", valB, 64'd4);
    chk("add.valE", valE, 64'd104);
    tick();
    chk("add.rbp", rbp, 64'd104);
    chk_cc("add", 1'b0, 1'b0, 1'b0);

    // subq %rbp, %rbp
    instr(4'h6, 4'h1, 4'h5, 4'h5, 64'd0, 64'd34, 64'd0);
    chk("sub.valE", valE, 64'd0);
    tick();
    chk("sub.rbp", rbp, 64'd0);
    chk_cc("sub", 1'b1, 1'b0, 1'b0);

    instr(4'h3, 4'h0, 4'hF, 4'h3, 64'd33, 64'd40, 64'd0); tick();
    // cmovne %rdx, %rbx with ZF=1: not taken
    instr(4'h2, 4'h4, 4'h2, 4'h3, 64'd0, 64'd42, 64'd0);
    chk("cmovne.Cnd", {63'd0, Cnd}, 64'd0);
    tick();
    chk("cmovne.rbx", rbx, 64'd33);
    // cmove %rdx, %rbx: taken
    instr(4'h2, 4'h3, 4'h2, 4'h3, 64'd0, 64'd44, 64'd0);
    chk("cmove.Cnd", {63'd0, Cnd}, 64'd1);
    chk("cmove.valE", valE, 64'd120);
    tick();
    chk("cmove.rbx", rbx, 64'd120);

    // signed overflow: 0x7FFF...F + 1
    instr(4'h3, 4'h0, 4'hF, 4'h6, 64'h7FFF_FFFF_FFFF_FFFF, 64'd50, 64'd0); tick();
    instr(4'h3, 4'h0, 4'hF, 4'h7, 64'd1, 64'd52, 64'd0); tick();
    instr(4'h6, 4'h0, 4'h7, 4'h6, 64'd0, 64'd54, 64'd0);
    chk("ovf.valE", valE, 64'h8000_0000_0000_0000);
    tick();
    chk_cc("ovf", 1'b0, 1'b1, 1'b1);
    chk("ovf.rsi", rsi, 64'h8000_0000_0000_0000);

    // subq %rdi, %rax: 0 - 1 = -1 gives SF=1, OF=0
    instr(4'h6, 4'h1, 4'h7, 4'h0, 64'd0, 64'd55, 64'd0); tick();
    chk("neg.rax", rax, 64'hFFFF_FFFF_FFFF_FFFF);
    chk_cc("neg", 1'b0, 1'b1, 1'b0);
    instr(4'h7, 4'h2, 4'hF, 4'hF, 64'd56, 64'd55, 64'd0);
    chk("jl.taken.Cnd", {63'd0, Cnd}, 64'd1);
    chk("jl.taken.PC", PC_next, 64'd56);
    tick();
    // addq %rdi, %rax: -1 + 1 = 0 gives SF=0
    instr(4'h6, 4'h0, 4'h7, 4'h0, 64'd0, 64'd56, 64'd0); tick();
    chk_cc("zero", 1'b1, 1'b0, 1'b0);
    instr(4'h7, 4'h2, 4'hF, 4'hF, 64'd56, 64'd55, 64'd0);
    chk("jl.not.PC", PC_next, 64'd55);

    // stack: call, ret, mrmovq, popq %rsp
    instr(4'h3, 4'h0, 4'hF, 4'h4, 64'd64, 64'd60, 64'd0); tick();
    instr(4'h8, 4'h0, 4'hF, 4'hF, 64'd80, 64'd61, 64'd0);
    chk("call.valE", valE, 64'd56);
    chk("call.PC", PC_next, 64'd80);
    tick();
    chk("call.rsp", rsp, 64'd56);
    instr(4'h9, 4'h0, 4'hF, 4'hF, 64'd0, 64'd81, 64'd69);
    chk("ret.valA", valA, 64'd56);
    chk("ret.PC", PC_next, 64'd69);
    tick();
    chk("ret.rsp", rsp, 64'd64);
    instr(4'h5, 4'h0, 4'h8, 4'h4, 64'd10, 64'd70, 64'h55);
    chk("mrmov.valE", valE, 64'd74);
    tick();
    chk("mrmov.r8", r8, 64'h55);
    instr(4'hB, 4'h0, 4'h4, 4'hF, 64'd0, 64'd72, 64'd7);
    chk("pop.valE", valE, 64'd72);
    tick();
    chk("pop.rsp", rsp, 64'd7);

    // invalid OPq function: valE=0, flags hold
    instr(4'h6, 4'h7, 4'h1, 4'h9, 64'd0, 64'd74, 64'd0);
    chk("opbad.valE", valE, 64'd0);
    tick();
    chk_cc("opbad", 1'b1, 1'b0, 1'b0);

    // halt: nothing changes, PC falls through
    instr(4'h0, 4'h0, 4'h1, 4'h2, 64'd999, 64'd99, 64'd5);
    chk("halt.PC", PC_next, 64'd99);
    tick();
    chk("halt.rcx", rcx, 64'd100);
    chk("halt.rdx", rdx, 64'd120);
    chk_cc("halt", 1'b1, 1'b0, 1'b0);

    // reset overrides a concurrent irmovq
    instr(4'h3, 4'h0, 4'hF, 4'hA, 64'd5, 64'd100, 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstw.r10", r10, 64'd0);
    chk("rstw.rdx", rdx, 64'd0);
    chk("rstw.rsp", rsp, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
